// File: rtl/lift_request_scheduler.sv
// Two-floor lift sequencer: latches hall and car calls, orders departures, and
// times travel and door intervals for the lamp, LED and buzzer front end.
module lift_request_scheduler #(
  parameter int TRAVEL_CYCLES = 200000000,
  parameter int DOOR_CYCLES   = 100000000,
  parameter int CNT_W         = 28
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       to_one,
  input  logic       to_two,
  input  logic       start_stop,
  output logic [3:0] pending,
  output logic [1:0] state,
  output logic [1:0] floor,
  output logic       door_open,
  output logic       arrive
);

  typedef enum logic [1:0] {HOMING, IDLE, MOVE, DOOR} fsm_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Pending bit order is {to_two, to_one, up, down}; each mask selects the
  // calls whose destination is that floor.
  localparam logic [3:0] T1_MASK = 4'b0110;
  localparam logic [3:0] T2_MASK = 4'b1001;

  fsm_t             fsm_q,    fsm_d;
  logic [CNT_W-1:0] timer_q,  timer_d;
  logic [3:0]       pend_q,   pend_d;
  logic             at_two_q, at_two_d;
  logic             dir_up_q, dir_up_d;
  logic             arrive_q, arrive_d;

  logic [3:0] req_vec;
  logic [3:0] here_mask;
  logic [3:0] there_mask;
  logic       req_here;
  logic       want_there;

  assign req_vec    = {to_two, to_one, up, down};
  assign here_mask  = at_two_q ? T2_MASK : T1_MASK;
  assign there_mask = ~here_mask;
  assign req_here   = |(req_vec & here_mask);
  assign want_there = |((pend_q | req_vec) & there_mask);

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      fsm_q    <= HOMING;
      timer_q  <= '0;
      pend_q   <= '0;
      at_two_q <= 1'b0;
      dir_up_q <= 1'b0;
      arrive_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      fsm_q    <= fsm_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      at_two_q <= at_two_d;
      dir_up_q <= dir_up_d;
      arrive_q <= arrive_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    fsm_d    = fsm_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    at_two_d = at_two_q;
    dir_up_d = dir_up_q;
    arrive_d = 1'b0;

    case (fsm_q)
      HOMING: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          fsm_d   = IDLE;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end

      IDLE: begin
        pend_d = pend_q | (req_vec & there_mask);
        if (req_here) begin
          fsm_d   = DOOR;
          timer_d = '0;
        end else if (start_stop && want_there) begin
          fsm_d    = MOVE;
          timer_d  = '0;
          dir_up_d = ~at_two_q;
        end
      end

      MOVE: begin
        // Calls for the floor being left are kept and served on the way back.
        pend_d = pend_q | req_vec;
        if (start_stop) begin
          if (timer_q == TRAVEL_LAST) begin
            at_two_d = ~at_two_q;
            pend_d   = (pend_q | req_vec) & ~there_mask;
            arrive_d = 1'b1;
            fsm_d    = DOOR;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
      end

      DOOR: begin
        pend_d = pend_q | (req_vec & there_mask);
        if (req_here) begin
          timer_d = '0;
        end else if (start_stop) begin
          if (timer_q == DOOR_LAST) begin
            timer_d = '0;
            fsm_d   = IDLE;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
      end

      default: fsm_d = HOMING;
    endcase
  end

  always_comb begin
    case (fsm_q)
      HOMING:  state = 2'd3;
      MOVE:    state = dir_up_q ? 2'd2 : 2'd1;
      default: state = 2'd0;
    endcase
    door_open = (fsm_q == DOOR);
    floor     = at_two_q ? 2'd2 : 2'd1;
    pending   = pend_q;
    arrive    = arrive_q;
  end

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Scenario bench for lift_request_scheduler with short timers; arrivals are
// scored against a queue of expected arrival records.
`timescale 1ns/1ps
module tb_lift_request_scheduler;

  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;

  logic       clk_50mhz = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       to_one = 1'b0;
  logic       to_two = 1'b0;
  logic       start_stop = 1'b0;
  logic [3:0] pending;
  logic [1:0] state;
  logic [1:0] floor;
  logic       door_open;
  logic       arrive;

  typedef struct {
    logic [1:0] floor;
    logic [3:0] pending;
    int         latency;
  } arr_t;

  arr_t exp_q[$];
  int checks = 0;
  int failures = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  lift_request_scheduler #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR),
    .CNT_W        (4)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .to_one    (to_one),
    .to_two    (to_two),
    .start_stop(start_stop),
    .pending   (pending),
    .state     (state),
    .floor     (floor),
    .door_open (door_open),
    .arrive    (arrive)
  );

  // Snapshot layout: {state[1:0], floor[1:0], pending[3:0], door_open, arrive}
  function automatic logic [9:0] snap();
    return {state, floor, pending, door_open, arrive};
  endfunction

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  // Starts right after rst is released; optionally pokes a call that must be ignored.
  task automatic check_homing(input string name, input bit poke);
    logic [9:0] o;
    for (int i = 0; i < TRAVEL; i++) begin
      to_two = poke && (i < 4);
      o = snap();
      checks++;
      if (o !== {2'd3, 2'd1, 4'b0000, 2'b00}) begin
        failures++;
        $display("FAIL %s_homing_c%0d got=%b exp=%b", name, i, o, {2'd3, 2'd1, 4'b0000, 2'b00});
      end
      step();
    end
    to_two = 1'b0;
    o = snap();
    checks++;
    if (o !== {2'd0, 2'd1, 4'b0000, 2'b00}) begin
      failures++;
      $display("FAIL %s_homing_done got=%b exp=%b", name, o, {2'd0, 2'd1, 4'b0000, 2'b00});
    end
  endtask

  // Steps until arrive, pops the scoreboard and compares outputs and latency.
  task automatic wait_arrive(input string name, input int offset);
    int n;
    arr_t e;
    logic [9:0] o;
    logic [9:0] x;
    n = 0;
    while (arrive !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard got=empty exp=entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (arrive !== 1'b1) begin
      failures++;
      $display("FAIL %s_arrive_timeout got=none exp=latency_%0d", name, e.latency);
      return;
    end
    x = {2'd0, e.floor, e.pending, 2'b11};
    o = snap();
    checks++;
    if (o !== x) begin
      failures++;
      $display("FAIL %s_arrival got=%b exp=%b", name, o, x);
    end
    checks++;
    if (offset + n !== e.latency) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, offset + n, e.latency);
    end
  endtask

  // Called on the first door cycle; door stays open DOOR cycles then closes.
  task automatic close_door(input string name, input logic [1:0] fl, input logic [3:0] pd);
    logic [9:0] o;
    for (int i = 1; i < DOOR; i++) begin
      step();
      o = snap();
      checks++;
      if (o !== {2'd0, fl, pd, 2'b10}) begin
        failures++;
        $display("FAIL %s_door_c%0d got=%b exp=%b", name, i, o, {2'd0, fl, pd, 2'b10});
      end
    end
    step();
    o = snap();
    checks++;
    if (o !== {2'd0, fl, pd, 2'b00}) begin
      failures++;
      $display("FAIL %s_door_closed got=%b exp=%b", name, o, {2'd0, fl, pd, 2'b00});
    end
  endtask

  task automatic test_reset();
    logic [9:0] o;
    rst = 1'b0;
    up = 1'b1;
    to_two = 1'b1;
    start_stop = 1'b1;
    step();
    step();
    o = snap();
    checks++;
    if (o !== {2'd3, 2'd1, 4'b0000, 2'b00}) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", o, {2'd3, 2'd1, 4'b0000, 2'b00});
    end
    up = 1'b0;
    to_two = 1'b0;
    rst = 1'b1;
    check_homing("reset", 1'b1);
  endtask

  task automatic test_up_run();
    logic [9:0] o;
    to_two = 1'b1;
    step();
    to_two = 1'b0;
    o = snap();
    checks++;
    if (o !== {2'd2, 2'd1, 4'b1000, 2'b00}) begin
      failures++;
      $display("FAIL up_run_depart got=%b exp=%b", o, {2'd2, 2'd1, 4'b1000, 2'b00});
    end
    exp_q.push_back('{2'd2, 4'b0000, TRAVEL});
    wait_arrive("up_run", 0);
    close_door("up_run", 2'd2, 4'b0000);
  endtask

  task automatic test_same_cycle();
    logic [9:0] o;
    down = 1'b1;
    to_one = 1'b1;
    step();
    down = 1'b0;
    to_one = 1'b0;
    o = snap();
    checks++;
    if (o !== {2'd0, 2'd2, 4'b0100, 2'b10}) begin
      failures++;
      $display("FAIL same_cycle_door got=%b exp=%b", o, {2'd0, 2'd2, 4'b0100, 2'b10});
    end
    close_door("same_cycle", 2'd2, 4'b0100);
    step();
    o = snap();
    checks++;
    if (o !== {2'd1, 2'd2, 4'b0100, 2'b00}) begin
      failures++;
      $display("FAIL same_cycle_depart got=%b exp=%b", o, {2'd1, 2'd2, 4'b0100, 2'b00});
    end
    exp_q.push_back('{2'd1, 4'b0000, TRAVEL});
    wait_arrive("same_cycle", 0);
    close_door("same_cycle_f1", 2'd1, 4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [9:0] o;
    to_two = 1'b1;
    step();
    to_two = 1'b0;
    exp_q.push_back('{2'd2, 4'b0010, TRAVEL});
    step();
    step();
    up = 1'b1;
    step();
    up = 1'b0;
    o = snap();
    checks++;
    if (o !== {2'd2, 2'd1, 4'b1010, 2'b00}) begin
      failures++;
      $display("FAIL b2b_latch got=%b exp=%b", o, {2'd2, 2'd1, 4'b1010, 2'b00});
    end
    wait_arrive("b2b_up", 3);
    close_door("b2b_f2", 2'd2, 4'b0010);
    step();
    o = snap();
    checks++;
    if (o !== {2'd1, 2'd2, 4'b0010, 2'b00}) begin
      failures++;
      $display("FAIL b2b_depart_down got=%b exp=%b", o, {2'd1, 2'd2, 4'b0010, 2'b00});
    end
    exp_q.push_back('{2'd1, 4'b0000, TRAVEL});
    wait_arrive("b2b_down", 0);
    close_door("b2b_f1", 2'd1, 4'b0000);
  endtask

  task automatic test_mid_reset();
    logic [9:0] o;
    to_two = 1'b1;
    step();
    to_two = 1'b0;
    repeat (4) step();
    o = snap();
    checks++;
    if (o !== {2'd2, 2'd1, 4'b1000, 2'b00}) begin
      failures++;
      $display("FAIL mid_reset_moving got=%b exp=%b", o, {2'd2, 2'd1, 4'b1000, 2'b00});
    end
    rst = 1'b0;
    #1;
    o = snap();
    checks++;
    if (o !== {2'd3, 2'd1, 4'b0000, 2'b00}) begin
      failures++;
      $display("FAIL mid_reset_clear got=%b exp=%b", o, {2'd3, 2'd1, 4'b0000, 2'b00});
    end
    step();
    rst = 1'b1;
    check_homing("mid_reset", 1'b0);
  endtask

  task automatic test_pause();
    logic [9:0] o;
    start_stop = 1'b0;
    to_two = 1'b1;
    step();
    to_two = 1'b0;
    for (int i = 0; i < 2; i++) begin
      o = snap();
      checks++;
      if (o !== {2'd0, 2'd1, 4'b1000, 2'b00}) begin
        failures++;
        $display("FAIL pause_blocked_c%0d got=%b exp=%b", i, o, {2'd0, 2'd1, 4'b1000, 2'b00});
      end
      step();
    end
    start_stop = 1'b1;
    step();
    o = snap();
    checks++;
    if (o !== {2'd2, 2'd1, 4'b1000, 2'b00}) begin
      failures++;
      $display("FAIL pause_depart got=%b exp=%b", o, {2'd2, 2'd1, 4'b1000, 2'b00});
    end
    exp_q.push_back('{2'd2, 4'b0000, TRAVEL + 5});
    repeat (3) step();
    start_stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      o = snap();
      checks++;
      if (o !== {2'd2, 2'd1, 4'b1000, 2'b00}) begin
        failures++;
        $display("FAIL pause_frozen_c%0d got=%b exp=%b", i, o, {2'd2, 2'd1, 4'b1000, 2'b00});
      end
    end
    start_stop = 1'b1;
    wait_arrive("pause", 8);
  endtask

  // Continues from the first door cycle at floor 2 left by test_pause.
  task automatic test_door_reopen();
    logic [9:0] o;
    step();
    to_two = 1'b1;
    step();
    to_two = 1'b0;
    o = snap();
    checks++;
    if (o !== {2'd0, 2'd2, 4'b0000, 2'b10}) begin
      failures++;
      $display("FAIL reopen got=%b exp=%b", o, {2'd0, 2'd2, 4'b0000, 2'b10});
    end
    close_door("reopen", 2'd2, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_up_run();
    test_same_cycle();
    test_back_to_back();
    test_mid_reset();
    test_pause();
    test_door_reopen();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
